// File: rtl/spi_slave_rx.sv
// -----------------------------------------------------------------------------
// spi_slave_rx
// Receive-only SPI slave deserializer. Consumes the debounced, i_clk-synchronous
// SPI lines, assembles MOSI bits into DATA_WIDTH-bit words and buffers completed
// words in a FIFO that is drained through a valid/ready handshake.
//
// Ports:
//   i_clk          system clock, the only clock domain
//   i_rst_n        asynchronous active-low reset
//   spi_clk_db     debounced SPI clock
//   spi_mosi_db    debounced MOSI
//   spi_cs_n_db    debounced chip select, active low
//   o_data         head-of-FIFO word
//   o_valid        o_data holds a valid word
//   i_ready        consumer accepts o_data when o_valid && i_ready
//   o_fifo_count   number of words currently buffered
//   o_overflow     one-cycle pulse when a completed word is dropped (FIFO full)
//   o_frame_end    one-cycle pulse when CS deasserts and ends an active frame
//   o_busy         high while a frame is active
//   o_frame_err    one-cycle pulse when a frame ends mid-word
//
// Optional feature macro: SPI_RX_FRAME_ERR_EN
//   Defined   : o_frame_err pulses alongside o_frame_end when the frame ended
//               with a partial word.
//   Undefined : o_frame_err is tied to 0 and partial words vanish silently.
// -----------------------------------------------------------------------------
module spi_slave_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0,
    parameter int MSB_FIRST  = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          spi_clk_db,
    input  logic                          spi_mosi_db,
    input  logic                          spi_cs_n_db,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_overflow,
    output logic                          o_frame_end,
    output logic                          o_busy,
    output logic                          o_frame_err
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(DATA_WIDTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]  ONE_BIT  = CNT_W'(1);
    localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(FIFO_DEPTH);
    localparam logic [FCNT_W-1:0] ONE_CNT  = FCNT_W'(1);
    localparam logic [PTR_W-1:0]  ONE_PTR  = PTR_W'(1);
    localparam bit SAMPLE_ON_RISE = (CPOL == CPHA);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  sclk_prev;
    logic                  cs_n_prev;
    logic                  sample_edge;
    logic                  cs_fall;
    logic                  cs_rise;
    logic                  shift_en;
    logic                  word_done;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [CNT_W-1:0]      bit_cnt;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      rd_ptr_next;
    logic [FCNT_W-1:0]     count_next;
    logic [FCNT_W-1:0]     remaining;
    logic [DATA_WIDTH-1:0] data_next;
    logic                  pop;
    logic                  full;
    logic                  do_push;
    logic                  overflow_next;

    // Sample edge is a rise when CPOL==CPHA, otherwise a fall. Shifting is
    // suppressed whenever CS is high, which also makes a CS rise win over a
    // coincident sample edge.
    assign sample_edge = SAMPLE_ON_RISE ? (spi_clk_db & ~sclk_prev)
                                        : (~spi_clk_db & sclk_prev);
    assign cs_fall   = ~spi_cs_n_db & cs_n_prev;
    assign cs_rise   = spi_cs_n_db & ~cs_n_prev;
    assign shift_en  = (state == ACTIVE) && !spi_cs_n_db && sample_edge;
    assign word_done = shift_en && (bit_cnt == LAST_BIT);

    // Previous-value registers for edge detection; SCLK idles at CPOL.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sclk_prev <= (CPOL != 0);
            cs_n_prev <= 1'b1;
        end else begin
            sclk_prev <= spi_clk_db;
            cs_n_prev <= spi_cs_n_db;
        end
    end

    // Frame state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame state transitions: CS fall opens a frame, CS rise closes it.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (cs_fall) state_next = ACTIVE;
            ACTIVE:  if (cs_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bit order decides which end of the shift register the new bit enters.
    always_comb begin
        shift_next = shift_reg;
        if (MSB_FIRST != 0) begin
            shift_next = {shift_reg[DATA_WIDTH-2:0], spi_mosi_db};
        end else begin
            shift_next = {spi_mosi_db, shift_reg[DATA_WIDTH-1:1]};
        end
    end

    // Any frame boundary clears the partial word so every frame starts at bit 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (state_next != state) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (shift_en) begin
            shift_reg <= shift_next;
            bit_cnt   <= word_done ? '0 : bit_cnt + ONE_BIT;
        end
    end

    // A full FIFO still accepts a push if the head leaves in the same cycle.
    assign pop           = o_valid && i_ready;
    assign full          = (o_fifo_count == FULL_CNT);
    assign do_push       = word_done && (!full || pop);
    assign overflow_next = word_done && full && !pop;
    assign rd_ptr_next   = pop ? rd_ptr + ONE_PTR : rd_ptr;
    assign remaining     = pop ? o_fifo_count - ONE_CNT : o_fifo_count;

    // Next count and next head word. When no older word survives, the word
    // being pushed becomes the head; o_data holds its value when empty.
    always_comb begin
        count_next = o_fifo_count;
        data_next  = o_data;
        if (do_push && !pop) begin
            count_next = o_fifo_count + ONE_CNT;
        end else if (!do_push && pop) begin
            count_next = o_fifo_count - ONE_CNT;
        end
        if (count_next != '0) begin
            data_next = (remaining == '0) ? shift_next : mem[rd_ptr_next];
        end
    end

    // Storage array; contents are meaningless unless covered by the count.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= shift_next;
        end
    end

    // FIFO pointers and all registered status outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_fifo_count <= '0;
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_overflow   <= 1'b0;
            o_frame_end  <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            rd_ptr       <= rd_ptr_next;
            o_fifo_count <= count_next;
            o_valid      <= (count_next != '0);
            o_data       <= data_next;
            o_overflow   <= overflow_next;
            o_frame_end  <= (state == ACTIVE) && cs_rise;
            o_busy       <= (state_next == ACTIVE);
        end
    end

`ifdef SPI_RX_FRAME_ERR_EN
    logic frame_err_next;

    assign frame_err_next = (state == ACTIVE) && cs_rise && (bit_cnt != '0);

    // Flags a frame that closed with a partial word pending.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_frame_err <= 1'b0;
        end else begin
            o_frame_err <= frame_err_next;
        end
    end
`else
    assign o_frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_rx
// Bench for spi_slave_rx. Two instances share clock and reset:
//   index 0 : mode 0 (CPOL=0, CPHA=0), MSB first
//   index 1 : mode 3 (CPOL=1, CPHA=1), LSB first
// Expected words come from a queue-based model that regroups the driven line
// bits into words by plain arithmetic; a monitor checks every handshake pop.
// -----------------------------------------------------------------------------
module tb_spi_slave_rx;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic          sclk [2];
    logic          mosi [2];
    logic          csn [2];
    logic          ready_fix [2];
    logic          ready_rand [2];
    logic          rand_mode [2];
    logic          ready [2];
    logic [DW-1:0] data_o [2];
    logic          valid_o [2];
    logic [2:0]    count_o [2];
    logic          ovf_o [2];
    logic          fe_o [2];
    logic          busy_o [2];
    logic          ferr_o [2];

    logic [DW-1:0] exp_q0 [$];
    logic [DW-1:0] exp_q1 [$];
    bit            line_bits [$];
    int            n_checks;
    int            n_fails;
    int            ovf_exp [2];
    int            ovf_seen [2];
    int            fe_exp [2];
    int            fe_seen [2];
    int            ferr_exp [2];
    int            ferr_seen [2];
    int            hook_bits;
    logic [DW-1:0] hook_acc;
    bit            latency_probe;

    assign ready[0] = rand_mode[0] ? ready_rand[0] : ready_fix[0];
    assign ready[1] = rand_mode[1] ? ready_rand[1] : ready_fix[1];

    spi_slave_rx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) dut_m0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .spi_clk_db(sclk[0]), .spi_mosi_db(mosi[0]), .spi_cs_n_db(csn[0]),
        .o_data(data_o[0]), .o_valid(valid_o[0]), .i_ready(ready[0]),
        .o_fifo_count(count_o[0]), .o_overflow(ovf_o[0]), .o_frame_end(fe_o[0]),
        .o_busy(busy_o[0]), .o_frame_err(ferr_o[0])
    );

    spi_slave_rx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CPOL(1), .CPHA(1), .MSB_FIRST(0)) dut_m3 (
        .i_clk(clk), .i_rst_n(rst_n),
        .spi_clk_db(sclk[1]), .spi_mosi_db(mosi[1]), .spi_cs_n_db(csn[1]),
        .o_data(data_o[1]), .o_valid(valid_o[1]), .i_ready(ready[1]),
        .o_fifo_count(count_o[1]), .o_overflow(ovf_o[1]), .o_frame_end(fe_o[1]),
        .o_busy(busy_o[1]), .o_frame_err(ferr_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Random consumer back-pressure, used only when rand_mode is set.
    initial begin
        ready_rand[0] = 1'b0;
        ready_rand[1] = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ready_rand[0] = 1'($urandom_range(0, 1));
            ready_rand[1] = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected run to complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int qSize(input int sel);
        return (sel == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [DW-1:0] qPop(input int sel);
        return (sel == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    endfunction

    // A word arriving at a full buffer is lost and counted as an overflow.
    task automatic modelPush(input int sel, input logic [DW-1:0] w);
        if (qSize(sel) >= DEPTH) ovf_exp[sel]++;
        else if (sel == 0) exp_q0.push_back(w);
        else exp_q1.push_back(w);
    endtask

    // Serializes a word in the bit order of the selected instance.
    task automatic appendWord(input int sel, input logic [DW-1:0] w);
        for (int i = 0; i < DW; i++) begin
            line_bits.push_back((sel == 0) ? w[DW-1-i] : w[i]);
        end
    endtask

    // Called right after a rising SCLK (the sample edge of both instances).
    task automatic sampleHook(input int sel);
        if (sel == 0) hook_acc = hook_acc * 2 + DW'(mosi[sel]);
        else hook_acc = hook_acc + (DW'(mosi[sel]) << hook_bits);
        hook_bits++;
        if (hook_bits == DW) begin
            modelPush(sel, hook_acc);
            hook_bits = 0;
            hook_acc  = '0;
            if (latency_probe) begin
                @(negedge clk);
                checkOutput("latency_push_cycle", valid_o[sel], 0);
                @(negedge clk);
                checkOutput("latency_next_cycle", valid_o[sel], 1);
            end
        end
    endtask

    // Drives one frame carrying line_bits; optionally closes it with CS rise.
    task automatic applyStimulus(input int sel, input bit end_frame, input int half);
        bit partial;
        hook_bits = 0;
        hook_acc  = '0;
        csn[sel]  = 1'b0;
        tick(2);
        checkOutput("busy_in_frame", busy_o[sel], 1);
        foreach (line_bits[i]) begin
            mosi[sel] = line_bits[i];
            tick(half);
            sclk[sel] = ~sclk[sel];
            if (sclk[sel]) sampleHook(sel);
            tick(half);
            sclk[sel] = ~sclk[sel];
            if (sclk[sel]) sampleHook(sel);
            tick(half);
        end
        if (end_frame) begin
            partial  = (hook_bits != 0);
            csn[sel] = 1'b1;
            tick(1);
            @(negedge clk);
            checkOutput("frame_end_pulse", fe_o[sel], 1);
`ifdef SPI_RX_FRAME_ERR_EN
            checkOutput("frame_err_pulse", ferr_o[sel], 32'(partial));
            if (partial) ferr_exp[sel]++;
`else
            checkOutput("frame_err_pulse", ferr_o[sel], 0);
`endif
            checkOutput("busy_after_frame", busy_o[sel], 0);
            fe_exp[sel]++;
            tick(1);
        end
        line_bits.delete();
    endtask

    task automatic waitDrain(input int sel);
        for (int i = 0; i < 400; i++) begin
            if (count_o[sel] == 0 && qSize(sel) == 0 && !valid_o[sel]) break;
            tick(1);
        end
        @(negedge clk);
        checkOutput("drain_count", 32'(count_o[sel]), 0);
        checkOutput("drain_model_left", qSize(sel), 0);
    endtask

    // Every accepted word must match the model head, in order.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int s = 0; s < 2; s++) begin
                if (ovf_o[s])  ovf_seen[s]++;
                if (fe_o[s])   fe_seen[s]++;
                if (ferr_o[s]) ferr_seen[s]++;
                if (valid_o[s] && ready[s]) begin
                    if (qSize(s) == 0) checkOutput("pop_unexpected", 32'(valid_o[s]), 0);
                    else checkOutput((s == 0) ? "pop_data_m0" : "pop_data_m3", 32'(data_o[s]), 32'(qPop(s)));
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] w;
        int            nw;
        int            extra;
        rst_n = 1'b0;
        latency_probe = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sclk[s] = (s == 1);
            mosi[s] = 1'b0;
            csn[s] = 1'b1;
            ready_fix[s] = 1'b0;
            rand_mode[s] = 1'b0;
        end
        tick(3);
        @(negedge clk);
        checkOutput("reset_valid", valid_o[0], 0);
        checkOutput("reset_count", 32'(count_o[0]), 0);
        checkOutput("reset_data", 32'(data_o[0]), 0);
        checkOutput("reset_busy", busy_o[1], 0);
        checkOutput("reset_overflow", ovf_o[1], 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        $display("[TB] mode 0 single word with latency probe");
        appendWord(0, 8'hA5);
        latency_probe = 1'b1;
        applyStimulus(0, 1, 2);
        latency_probe = 1'b0;
        checkOutput("m0_count", 32'(count_o[0]), 1);
        checkOutput("m0_data", 32'(data_o[0]), 32'hA5);
        ready_fix[0] = 1'b1;
        @(negedge clk);
        checkOutput("m0_valid_on_accept", valid_o[0], 1);
        tick(1);
        @(negedge clk);
        checkOutput("m0_valid_one_cycle", valid_o[0], 0);
        checkOutput("m0_no_overflow", ovf_seen[0], 0);
        ready_fix[0] = 1'b0;

        $display("[TB] mode 3 back-to-back words");
        appendWord(1, 8'h3C);
        appendWord(1, 8'hC3);
        applyStimulus(1, 1, 2);
        checkOutput("m3_count_peak", 32'(count_o[1]), 2);
        checkOutput("m3_head", 32'(data_o[1]), 32'h3C);
        ready_fix[1] = 1'b1;
        waitDrain(1);
        ready_fix[1] = 1'b0;

        $display("[TB] overflow");
        for (int i = 1; i <= 5; i++) begin
            w = DW'(i);
            appendWord(0, w);
        end
        applyStimulus(0, 1, 1);
        checkOutput("ovf_count_full", 32'(count_o[0]), 4);
        checkOutput("ovf_head", 32'(data_o[0]), 32'h01);
        checkOutput("ovf_pulses", ovf_seen[0], ovf_exp[0]);
        ready_fix[0] = 1'b1;
        waitDrain(0);

        $display("[TB] abort after three bits");
        line_bits.push_back(1'b1);
        line_bits.push_back(1'b0);
        line_bits.push_back(1'b1);
        applyStimulus(0, 1, 2);
        checkOutput("abort_count", 32'(count_o[0]), 0);
        appendWord(0, 8'h5A);
        applyStimulus(0, 1, 2);
        waitDrain(0);
        ready_fix[0] = 1'b0;

        $display("[TB] LSB first and idle clocking");
        line_bits.push_back(1'b1);
        for (int i = 0; i < 7; i++) line_bits.push_back(1'b0);
        applyStimulus(1, 1, 2);
        checkOutput("lsb_data", 32'(data_o[1]), 32'h01);
        ready_fix[1] = 1'b1;
        waitDrain(1);
        for (int i = 0; i < 8; i++) begin
            sclk[1] = ~sclk[1];
            tick(2);
        end
        @(negedge clk);
        checkOutput("idle_clk_count", 32'(count_o[1]), 0);
        checkOutput("idle_clk_valid", valid_o[1], 0);

        $display("[TB] async reset mid-frame");
        appendWord(0, DW'($urandom));
        appendWord(0, DW'($urandom));
        for (int i = 0; i < 5; i++) line_bits.push_back(1'($urandom_range(0, 1)));
        applyStimulus(0, 0, 2);
        @(negedge clk);
        checkOutput("pre_reset_count", 32'(count_o[0]), 2);
        #2;
        rst_n  = 1'b0;
        csn[0] = 1'b1;
        #1;
        checkOutput("reset_mid_valid", valid_o[0], 0);
        checkOutput("reset_mid_count", 32'(count_o[0]), 0);
        checkOutput("reset_mid_busy", busy_o[0], 0);
        exp_q0.delete();
        tick(2);
        rst_n = 1'b1;
        tick(2);
        appendWord(0, 8'hFF);
        applyStimulus(0, 1, 2);
        checkOutput("post_reset_data", 32'(data_o[0]), 32'hFF);
        ready_fix[0] = 1'b1;
        waitDrain(0);

        $display("[TB] randomized frames");
        rand_mode[0] = 1'b1;
        rand_mode[1] = 1'b1;
        for (int it = 0; it < 12; it++) begin
            nw    = $urandom_range(1, 3);
            extra = (it % 3 == 0) ? $urandom_range(1, DW - 1) : 0;
            for (int k = 0; k < nw; k++) appendWord(it % 2, DW'($urandom));
            for (int k = 0; k < extra; k++) line_bits.push_back(1'($urandom_range(0, 1)));
            applyStimulus(it % 2, 1, $urandom_range(1, 3));
        end
        rand_mode[0] = 1'b0;
        rand_mode[1] = 1'b0;
        ready_fix[0] = 1'b1;
        ready_fix[1] = 1'b1;
        waitDrain(0);
        waitDrain(1);

        for (int s = 0; s < 2; s++) begin
            checkOutput("total_overflow", ovf_seen[s], ovf_exp[s]);
            checkOutput("total_frame_end", fe_seen[s], fe_exp[s]);
            checkOutput("total_frame_err", ferr_seen[s], ferr_exp[s]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
